// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: funct3 access encodings, internal
// access-size codes and the byte-enable helper.
package mem_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  // Byte lanes touched by an access of the given size starting at the given lane.
  function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << lane;
      SZ_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_W:    be = 4'b1111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_stage_data_ram.sv
// Local data RAM: 32-bit words, per-byte write enables, combinational read so a
// load sees the contents as they were before the store at the same edge.
module data_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];

  // Byte-enabled write; contents are intentionally never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory stage: address decode, store lane replication, misalignment check,
// load extraction/extension and the memory/write-back pipeline register.
module mem_stage
  import mem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             regwriteM,
  input  logic [1:0]       resultsrcM,
  input  logic             memwriteM,
  input  logic             memreadM,
  input  logic [2:0]       memctrlM,
  input  logic [WIDTH-1:0] aluresultM,
  input  logic [WIDTH-1:0] writedataM,
  input  logic [4:0]       rdM,
  input  logic [WIDTH-1:0] pcplus4M,
  output logic             regwriteW,
  output logic [1:0]       resultsrcW,
  output logic [4:0]       rdW,
  output logic [WIDTH-1:0] aluresultW,
  output logic [WIDTH-1:0] pcplus4W,
  output logic [WIDTH-1:0] readdataW,
  output logic             misalignW
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [AW+1:0]    addr_s;
  logic [1:0]       lane_s;
  size_e            size_s;
  logic             illegal_s;
  logic             unaligned_s;
  logic             misalign_s;
  logic             we_s;
  logic [3:0]       be_s;
  logic [31:0]      wdata_s;
  logic [31:0]      rdata_s;
  logic [7:0]       lbyte_s;
  logic [15:0]      lhalf_s;
  logic [WIDTH-1:0] load_s;

  // Upper address bits are dropped so accesses wrap modulo the RAM size.
  assign addr_s = aluresultM[AW+1:0];
  assign lane_s = addr_s[1:0];

  // Access size decode and alignment check; illegal encodings count as word.
  always_comb begin
    size_s      = SZ_W;
    illegal_s   = 1'b0;
    unaligned_s = 1'b0;
    case (memctrlM)
      MEM_B, MEM_BU: size_s = SZ_B;
      MEM_H, MEM_HU: size_s = SZ_H;
      MEM_W:         size_s = SZ_W;
      default:       illegal_s = 1'b1;
    endcase
    case (size_s)
      SZ_B:    unaligned_s = 1'b0;
      SZ_H:    unaligned_s = lane_s[0];
      SZ_W:    unaligned_s = (lane_s != 2'b00);
      default: unaligned_s = 1'b1;
    endcase
  end

  assign misalign_s = (memreadM | memwriteM) & (illegal_s | unaligned_s);
  assign we_s       = memwriteM & ~misalign_s & ~rst;
  assign be_s       = byte_en(size_s, lane_s);

  // Replicate store data across lanes; byte enables pick the live ones.
  always_comb begin
    wdata_s = writedataM[31:0];
    case (size_s)
      SZ_B:    wdata_s = {4{writedataM[7:0]}};
      SZ_H:    wdata_s = {2{writedataM[15:0]}};
      SZ_W:    wdata_s = writedataM[31:0];
      default: wdata_s = writedataM[31:0];
    endcase
  end

  data_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .we    (we_s),
    .be    (be_s),
    .addr  (addr_s[AW+1:2]),
    .wdata (wdata_s),
    .rdata (rdata_s)
  );

  // Lane extraction and sign/zero extension of the addressed bytes.
  always_comb begin
    lbyte_s = rdata_s[7:0];
    lhalf_s = rdata_s[15:0];
    load_s  = WIDTH'(rdata_s);
    case (lane_s)
      2'b00:   lbyte_s = rdata_s[7:0];
      2'b01:   lbyte_s = rdata_s[15:8];
      2'b10:   lbyte_s = rdata_s[23:16];
      2'b11:   lbyte_s = rdata_s[31:24];
      default: lbyte_s = rdata_s[7:0];
    endcase
    if (lane_s[1]) begin
      lhalf_s = rdata_s[31:16];
    end else begin
      lhalf_s = rdata_s[15:0];
    end
    case (memctrlM)
      MEM_B:   load_s = {{(WIDTH-8){lbyte_s[7]}}, lbyte_s};
      MEM_BU:  load_s = WIDTH'(lbyte_s);
      MEM_H:   load_s = {{(WIDTH-16){lhalf_s[15]}}, lhalf_s};
      MEM_HU:  load_s = WIDTH'(lhalf_s);
      default: load_s = WIDTH'(rdata_s);
    endcase
  end

  // Memory/write-back pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwriteW  <= 1'b0;
      resultsrcW <= 2'b00;
      rdW        <= 5'd0;
      aluresultW <= {WIDTH{1'b0}};
      pcplus4W   <= {WIDTH{1'b0}};
      readdataW  <= {WIDTH{1'b0}};
      misalignW  <= 1'b0;
    end else begin
      regwriteW  <= regwriteM & ~misalign_s;
      resultsrcW <= resultsrcM;
      rdW        <= rdM;
      aluresultW <= aluresultM;
      pcplus4W   <= pcplus4M;
      readdataW  <= (memreadM && !misalign_s) ? load_s : {WIDTH{1'b0}};
      misalignW  <= misalign_s;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed test-plan steps followed by random
// accesses, checked against a byte-array model of the RAM.
module tb_mem_stage;

  localparam int DEPTH_WORDS = 1024;
  localparam int BYTES       = DEPTH_WORDS * 4;

  localparam logic [2:0] C_B  = 3'b000;
  localparam logic [2:0] C_H  = 3'b001;
  localparam logic [2:0] C_W  = 3'b010;
  localparam logic [2:0] C_BU = 3'b100;
  localparam logic [2:0] C_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        regwriteM = 1'b0;
  logic [1:0]  resultsrcM = 2'b00;
  logic        memwriteM = 1'b0;
  logic        memreadM = 1'b0;
  logic [2:0]  memctrlM = 3'b000;
  logic [31:0] aluresultM = 32'd0;
  logic [31:0] writedataM = 32'd0;
  logic [4:0]  rdM = 5'd0;
  logic [31:0] pcplus4M = 32'd0;
  logic        regwriteW;
  logic [1:0]  resultsrcW;
  logic [4:0]  rdW;
  logic [31:0] aluresultW;
  logic [31:0] pcplus4W;
  logic [31:0] readdataW;
  logic        misalignW;

  logic [7:0] mem_m [BYTES];
  int npass = 0;
  int nfail = 0;
  int ntotal = 0;

  mem_stage #(.WIDTH(32), .DEPTH_WORDS(DEPTH_WORDS)) dut (
    .clk(clk), .rst(rst),
    .regwriteM(regwriteM), .resultsrcM(resultsrcM), .memwriteM(memwriteM),
    .memreadM(memreadM), .memctrlM(memctrlM), .aluresultM(aluresultM),
    .writedataM(writedataM), .rdM(rdM), .pcplus4M(pcplus4M),
    .regwriteW(regwriteW), .resultsrcW(resultsrcW), .rdW(rdW),
    .aluresultW(aluresultW), .pcplus4W(pcplus4W), .readdataW(readdataW),
    .misalignW(misalignW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One instruction through M: model predicts W outputs and updates its RAM.
  task automatic step(input logic r, input logic mw, input logic mr,
                      input logic [2:0] ctrl, input logic [31:0] alu, input logic [31:0] wd);
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] v;
    int a, sz;
    bit ill, mis;
    rw = 1'($urandom);
    rs = 2'($urandom);
    rd = 5'($urandom);
    pc = $urandom;
    a   = int'(alu % BYTES);
    ill = (ctrl == 3'b011) || (ctrl == 3'b110) || (ctrl == 3'b111);
    if (ctrl == C_B || ctrl == C_BU) sz = 1;
    else if (ctrl == C_H || ctrl == C_HU) sz = 2;
    else sz = 4;
    mis = (mr || mw) && (ill || (a % sz) != 0);
    v = 32'd0;
    if (!mis) begin
      for (int i = 0; i < sz; i++) v = v | (32'(mem_m[a+i]) << (8*i));
      if (ctrl == C_B && v >= 32'd128) v = v - 32'd256;
      if (ctrl == C_H && v >= 32'd32768) v = v - 32'd65536;
    end
    if (!r && mw && !mis) begin
      for (int i = 0; i < sz; i++) mem_m[a+i] = wd[8*i +: 8];
    end

    @(negedge clk);
    rst = r; regwriteM = rw; resultsrcM = rs; memwriteM = mw; memreadM = mr;
    memctrlM = ctrl; aluresultM = alu; writedataM = wd; rdM = rd; pcplus4M = pc;
    @(posedge clk);
    #1;
    chk("regwriteW",  32'(regwriteW),  r ? 32'd0 : 32'(rw && !mis));
    chk("resultsrcW", 32'(resultsrcW), r ? 32'd0 : 32'(rs));
    chk("rdW",        32'(rdW),        r ? 32'd0 : 32'(rd));
    chk("aluresultW", aluresultW,      r ? 32'd0 : alu);
    chk("pcplus4W",   pcplus4W,        r ? 32'd0 : pc);
    chk("readdataW",  readdataW,       (r || !mr) ? 32'd0 : v);
    chk("misalignW",  32'(misalignW),  r ? 32'd0 : 32'(mis));
  endtask

  initial begin
    logic [2:0] ctrl_tab [8];
    logic [2:0] c;
    for (int i = 0; i < 8; i++) ctrl_tab[i] = 3'(i);

    step(1'b1, 1'b0, 1'b0, C_W, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, C_W, 32'd0, 32'd0);

    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 1'b0, C_W, 32'(4*i), $urandom);

    step(1'b0, 1'b1, 1'b0, C_W, 32'h10, 32'hDEADBEEF);
    step(1'b0, 1'b0, 1'b1, C_W, 32'h10, 32'd0);
    chk("tp_lw_deadbeef", readdataW, 32'hDEADBEEF);
    step(1'b0, 1'b1, 1'b0, C_B, 32'h12, 32'h00000055);
    step(1'b0, 1'b0, 1'b1, C_W, 32'h10, 32'd0);
    chk("tp_lw_after_sb", readdataW, 32'hDE55BEEF);
    step(1'b0, 1'b0, 1'b1, C_B, 32'h13, 32'd0);
    chk("tp_lb", readdataW, 32'hFFFFFFDE);
    step(1'b0, 1'b0, 1'b1, C_BU, 32'h13, 32'd0);
    chk("tp_lbu", readdataW, 32'h000000DE);
    step(1'b0, 1'b0, 1'b1, C_H, 32'h10, 32'd0);
    chk("tp_lh", readdataW, 32'hFFFFBEEF);
    step(1'b0, 1'b0, 1'b1, C_HU, 32'h10, 32'd0);
    chk("tp_lhu", readdataW, 32'h0000BEEF);

    step(1'b0, 1'b1, 1'b0, C_W, 32'h22, 32'h12345678);
    chk("tp_sw_mis", 32'(misalignW), 32'd1);
    step(1'b0, 1'b0, 1'b1, C_W, 32'h20, 32'd0);
    step(1'b0, 1'b0, 1'b1, C_H, 32'h11, 32'd0);
    chk("tp_lh_mis_rw", 32'(regwriteW), 32'd0);
    chk("tp_lh_mis_rd", readdataW, 32'd0);
    chk("tp_lh_mis_flag", 32'(misalignW), 32'd1);

    step(1'b0, 1'b0, 1'b1, C_W, 32'(BYTES + 32'h10), 32'd0);
    chk("tp_alias", readdataW, 32'hDE55BEEF);
    step(1'b0, 1'b1, 1'b0, C_W, 32'(3*BYTES + 32'h14), 32'hCAFEF00D);
    step(1'b0, 1'b0, 1'b1, C_W, 32'h14, 32'd0);
    chk("tp_alias_store", readdataW, 32'hCAFEF00D);

    step(1'b1, 1'b1, 1'b0, C_W, 32'h10, 32'h12345678);
    step(1'b0, 1'b0, 1'b1, C_W, 32'h10, 32'd0);
    chk("tp_rst_store", readdataW, 32'hDE55BEEF);

    step(1'b0, 1'b1, 1'b1, C_W, 32'h18, 32'hAAAA5555);
    step(1'b0, 1'b0, 1'b1, C_W, 32'h18, 32'd0);
    chk("tp_rbw_new", readdataW, 32'hAAAA5555);
    step(1'b0, 1'b1, 1'b0, C_W, 32'h18, 32'h0BADCAFE);

    for (int n = 0; n < 400; n++) begin
      c = ctrl_tab[$urandom_range(0, 7)];
      step(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), c,
           $urandom & 32'hFFFF_F0FF, $urandom);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
